dmem_responder: RTL and testbench

//  Data-side responder for the single-cycle core's store/load bus (DataAdr, WriteData, MemWrite).

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_responder_if.sv | 18 +
 rtl/dmem_trace_fifo.sv | 57 +++++
 rtl/dmem_responder.sv | 106 ++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Status encoding and default mailbox settings for dmem_responder.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] ST_RUNNING = 2'b00;
    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;

    localparam logic [31:0] DEF_PASS_ADDR  = 32'd100;
    localparam logic [31:0] DEF_PASS_VALUE = 32'd7;

    typedef enum logic [1:0] {
        S_RUNNING = ST_RUNNING,
        S_PASS    = ST_PASS,
        S_FAIL    = ST_FAIL
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_if
//  Purpose  : Core data-side store/load bus between core (master) and responder.
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_responder_if;

    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
    modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);

endinterface
`default_nettype wire

// File: rtl/dmem_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_trace_fifo
//  Purpose  : Store-trace FIFO with sticky overflow flag (used with DMEM_TRACE_EN).
//  Revision : 1.0  initial release
// ============================================================================
module dmem_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  wire              clk,
    input  wire              reset,
    input  wire              push,
    input  wire              pop,
    input  wire  [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             ovf
);

    localparam int c_ptrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptrW-1:0] r_wrPtr, r_rdPtr;
    logic [c_ptrW:0]   r_fill;
    logic              r_ovf;
    logic              w_full, w_push, w_pop;

    assign w_full = (r_fill == (c_ptrW+1)'(DEPTH));
    assign empty  = (r_fill == '0);
    assign w_pop  = pop & ~empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_push = push & (~w_full | w_pop);
    assign dout   = r_mem[r_rdPtr];
    assign ovf    = r_ovf;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_fill  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && !w_pop)      r_fill <= r_fill + 1'b1;
            else if (w_pop && !w_push) r_fill <= r_fill - 1'b1;
            if (push && !w_push) r_ovf <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data RAM plus pass/fail mailbox judge for the core's store bus.
//             Optional store trace FIFO enabled by macro DMEM_TRACE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] PASS_ADDR   = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_VALUE  = DEF_PASS_VALUE,
    parameter int          CNT_W       = 16
`ifdef DMEM_TRACE_EN
   ,parameter int          TRACE_DEPTH = 8
`endif
) (
    input  wire              clk,
    input  wire              reset,
    dmem_responder_if.slave  bus,
    output logic [1:0]       status,
    output logic             done,
    output logic [CNT_W-1:0] store_count
`ifdef DMEM_TRACE_EN
   ,output logic             trace_valid,
    input  wire              trace_rd,
    output logic [31:0]      trace_addr,
    output logic [31:0]      trace_data,
    output logic             trace_ovf
`endif
);

    localparam int          c_addrW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_byteLimit = 32'(4 * DEPTH_WORDS);

    state_t             r_state, w_nextState;
    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [CNT_W-1:0]   r_count;
    logic [c_addrW-1:0] w_wordIdx;
    logic               w_aligned, w_inRange, w_accept, w_ramWe;

    assign w_wordIdx    = bus.DataAdr[c_addrW+1:2];
    assign w_aligned    = (bus.DataAdr[1:0] == 2'b00);
    assign w_inRange    = (bus.DataAdr < c_byteLimit);
    assign bus.ReadData = w_inRange ? r_mem[w_wordIdx] : '0;

    assign status      = r_state;
    assign done        = (r_state != S_RUNNING);
    assign store_count = r_count;

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_ramWe     = 1'b0;
        if (r_state == S_RUNNING && bus.MemWrite) begin
            w_accept = 1'b1;
            w_ramWe  = w_aligned & w_inRange;
            if (bus.DataAdr == PASS_ADDR)
                w_nextState = (bus.WriteData == PASS_VALUE) ? S_PASS : S_FAIL;
            else if (!w_aligned || !w_inRange)
                w_nextState = S_FAIL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RUNNING;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept && r_count != {CNT_W{1'b1}})
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // RAM keeps contents across reset; a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && w_ramWe) r_mem[w_wordIdx] <= bus.WriteData;
    end

`ifdef DMEM_TRACE_EN
    logic [63:0] w_traceHead;
    logic        w_traceEmpty;

    dmem_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (64)
    ) u_trace (
        .clk   (clk),
        .reset (reset),
        .push  (w_accept),
        .pop   (trace_rd),
        .din   ({bus.DataAdr, bus.WriteData}),
        .dout  (w_traceHead),
        .empty (w_traceEmpty),
        .ovf   (trace_ovf)
    );

    assign trace_valid = ~w_traceEmpty;
    assign trace_addr  = w_traceHead[63:32];
    assign trace_data  = w_traceHead[31:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder (covers DMEM_TRACE_EN too).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus2 ();
    assign bus2.MemWrite  = bus.MemWrite;
    assign bus2.DataAdr   = bus.DataAdr;
    assign bus2.WriteData = bus.WriteData;

    logic [1:0]  status, status2;
    logic        done, done2;
    logic [15:0] count;
    logic [2:0]  count2;
    logic        tr_rd = 1'b0;
    logic        tr_valid, tr_valid2, tr_ovf, tr_ovf2;
    logic [31:0] tr_addr, tr_data, tr_addr2, tr_data2;

    dmem_responder dut (
        .clk(clk), .reset(reset), .bus(bus),
        .status(status), .done(done), .store_count(count)
`ifdef DMEM_TRACE_EN
       ,.trace_valid(tr_valid), .trace_rd(tr_rd), .trace_addr(tr_addr),
        .trace_data(tr_data), .trace_ovf(tr_ovf)
`endif
    );

    // Narrow counter instance so saturation is reachable in a short run.
    dmem_responder #(.CNT_W(3)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2),
        .status(status2), .done(done2), .store_count(count2)
`ifdef DMEM_TRACE_EN
       ,.trace_valid(tr_valid2), .trace_rd(1'b0), .trace_addr(tr_addr2),
        .trace_data(tr_data2), .trace_ovf(tr_ovf2)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: word memory, status, raw store count, trace queue.
    logic [31:0] m_mem [64];
    bit          m_known [64];
    logic [1:0]  m_status = ST_RUNNING;
    int          m_count = 0;
    logic [63:0] m_q [$];
    bit          m_ovf = 1'b0;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_status = ST_RUNNING;
        m_count  = 0;
        m_q.delete();
        m_ovf    = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        bit pop, full, legal;
        bus.DataAdr   = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        @(posedge clk);
        pop  = tr_rd && (m_q.size() != 0);
        full = (m_q.size() == 8);
        if (pop) void'(m_q.pop_front());
        if (m_status == ST_RUNNING) begin
            m_count++;
            if (!full || pop) m_q.push_back({a, d});
            else m_ovf = 1'b1;
            legal = (a % 4 == 0) && (a < 256);
            if (legal) begin
                m_mem[a / 4]   = d;
                m_known[a / 4] = 1'b1;
            end
            if (a == 100) m_status = (d == 7) ? ST_PASS : ST_FAIL;
            else if (!legal) m_status = ST_FAIL;
        end
        #1;
        bus.MemWrite = 1'b0;
    endtask

    task automatic do_pop();
        tr_rd = 1'b1;
        @(posedge clk);
        if (m_q.size() != 0) void'(m_q.pop_front());
        #1;
        tr_rd = 1'b0;
    endtask

    function automatic logic [31:0] rand_word_addr();
        int w;
        w = $urandom_range(0, 63);
        if (w == 25) w = 26;
        return 32'(w) << 2;
    endfunction

    task automatic test_reset();
        #1 reset = 1'b0;
        #20;
        checks++; if (status !== ST_RUNNING) begin errors++; $display("FAIL reset_status got=%b exp=%b", status, ST_RUNNING); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        #2 reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        do_store(32'd96, 32'd5);
        bus.DataAdr = 32'd96; #1;
        checks++; if (bus.ReadData !== 32'd5) begin errors++; $display("FAIL load96 got=%0d exp=5", bus.ReadData); end
        checks++; if (status !== m_status) begin errors++; $display("FAIL run_status got=%b exp=%b", status, m_status); end
        checks++; if (count !== 16'(m_count)) begin errors++; $display("FAIL count1 got=%0d exp=%0d", count, m_count); end
    endtask

    task automatic test_pass();
        do_store(32'd100, 32'd7);
        checks++; if (status !== ST_PASS) begin errors++; $display("FAIL pass_status got=%b exp=%b", status, ST_PASS); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pass_done got=%b exp=1", done); end
        do_store(32'd96, 32'd9);
        bus.DataAdr = 32'd96; #1;
        checks++; if (bus.ReadData !== m_mem[24]) begin errors++; $display("FAIL pass_ignore got=%0d exp=%0d", bus.ReadData, m_mem[24]); end
        checks++; if (count !== 16'(m_count)) begin errors++; $display("FAIL pass_count got=%0d exp=%0d", count, m_count); end
    endtask

    task automatic test_fail_value();
        apply_reset();
        do_store(32'd100, 32'd8);
        checks++; if (status !== ST_FAIL) begin errors++; $display("FAIL fail_status got=%b exp=%b", status, ST_FAIL); end
        bus.DataAdr = 32'd100; #1;
        checks++; if (bus.ReadData !== 32'd8) begin errors++; $display("FAIL fail_load100 got=%0d exp=8", bus.ReadData); end
    endtask

    task automatic test_bad_address();
        apply_reset();
        do_store(32'd98, 32'd1);
        checks++; if (status !== ST_FAIL) begin errors++; $display("FAIL misalign_status got=%b exp=%b", status, ST_FAIL); end
        bus.DataAdr = 32'd98; #1;
        checks++; if (bus.ReadData !== m_mem[24]) begin errors++; $display("FAIL misalign_ram got=%0d exp=%0d", bus.ReadData, m_mem[24]); end
        apply_reset();
        do_store(32'd256, 32'd1);
        checks++; if (status !== ST_FAIL) begin errors++; $display("FAIL range_status got=%b exp=%b", status, ST_FAIL); end
        checks++; if (count !== 16'(m_count)) begin errors++; $display("FAIL range_count got=%0d exp=%0d", count, m_count); end
        bus.DataAdr = 32'd256; #1;
        checks++; if (bus.ReadData !== 32'd0) begin errors++; $display("FAIL range_load got=%0d exp=0", bus.ReadData); end
    endtask

    task automatic test_random_store_load();
        int w;
        logic [31:0] a;
        apply_reset();
        for (int i = 0; i < 12; i++) do_store(rand_word_addr(), $urandom);
        checks++; if (status !== m_status) begin errors++; $display("FAIL rnd_status got=%b exp=%b", status, m_status); end
        checks++; if (count !== 16'(sat(m_count, 65535))) begin errors++; $display("FAIL rnd_count got=%0d exp=%0d", count, m_count); end
        checks++; if (count2 !== 3'(sat(m_count, 7))) begin errors++; $display("FAIL sat_count got=%0d exp=%0d", count2, sat(m_count, 7)); end
        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(0, 63);
            while (!m_known[w]) w = (w + 1) % 64;
            bus.DataAdr = (32'(w) << 2) + 32'($urandom_range(0, 3)); #1;
            checks++; if (bus.ReadData !== m_mem[w]) begin errors++; $display("FAIL rnd_load a=%0d got=%h exp=%h", bus.DataAdr, bus.ReadData, m_mem[w]); end
        end
        a = 32'd256 + 32'($urandom_range(0, 32'h7fff_0000));
        bus.DataAdr = a; #1;
        checks++; if (bus.ReadData !== 32'd0) begin errors++; $display("FAIL oob_load a=%h got=%h exp=0", a, bus.ReadData); end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        do_store(32'd0, 32'hA5A5_0001);
        do_store(32'd4, 32'hA5A5_0002);
        do_store(32'd98, 32'hA5A5_0003);
        checks++; if (count !== 16'(m_count)) begin errors++; $display("FAIL mid_count got=%0d exp=%0d", count, m_count); end
        bus.DataAdr = 32'd0; bus.WriteData = 32'hDEAD_BEEF; bus.MemWrite = 1'b1;
        reset = 1'b0;
        #1;
        model_reset();
        checks++; if (status !== ST_RUNNING) begin errors++; $display("FAIL mid_status got=%b exp=%b", status, ST_RUNNING); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL mid_count0 got=%0d exp=0", count); end
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
        reset = 1'b1;
        bus.DataAdr = 32'd0; #1;
        checks++; if (bus.ReadData !== m_mem[0]) begin errors++; $display("FAIL mid_lost got=%h exp=%h", bus.ReadData, m_mem[0]); end
    endtask

`ifdef DMEM_TRACE_EN
    task automatic test_trace();
        logic [63:0] first;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            do_store(rand_word_addr(), $urandom);
            if (i == 0) first = m_q[0];
        end
        checks++; if (tr_ovf !== 1'b1) begin errors++; $display("FAIL trace_ovf got=%b exp=1", tr_ovf); end
        checks++; if ({tr_addr, tr_data} !== first) begin errors++; $display("FAIL trace_head got=%h exp=%h", {tr_addr, tr_data}, first); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (tr_valid !== 1'b1 || {tr_addr, tr_data} !== m_q[0]) begin errors++; $display("FAIL trace_drain i=%0d got=%h exp=%h", i, {tr_addr, tr_data}, m_q[0]); end
            do_pop();
        end
        checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL trace_empty got=%b exp=0", tr_valid); end
        apply_reset();
        for (int i = 0; i < 8; i++) do_store(rand_word_addr(), $urandom);
        tr_rd = 1'b1;
        do_store(rand_word_addr(), $urandom);
        tr_rd = 1'b0;
        checks++; if (tr_ovf !== m_ovf) begin errors++; $display("FAIL trace_pushpop_ovf got=%b exp=%b", tr_ovf, m_ovf); end
        checks++; if ({tr_addr, tr_data} !== m_q[0]) begin errors++; $display("FAIL trace_pushpop_head got=%h exp=%h", {tr_addr, tr_data}, m_q[0]); end
    endtask
`endif

    initial begin
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;
        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
        test_reset();
        test_pass();
        test_fail_value();
        test_bad_address();
        test_random_store_load();
        test_reset_midrun();
`ifdef DMEM_TRACE_EN
        test_trace();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
